// File: rtl/sdr_pkt_pkg.sv
// Shared tags, FSM states and packet lengths for the host serial packet path.
// PKT_CHECKSUM_EN lengthens every packet by one XOR trailer byte.
package sdr_pkt_pkg;

   localparam logic [3:0] TAG_I    = 4'b1000;
   localparam logic [3:0] TAG_Q    = 4'b0100;
   localparam logic [3:0] TAG_STAT = 4'b1100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_HI,
      S_WAIT_LO,
      S_NEXT
   } tx_state_t;

`ifdef PKT_CHECKSUM_EN
   localparam logic [3:0] IQ_PKT_LEN   = 4'd11;
   localparam logic [3:0] STAT_PKT_LEN = 4'd6;
`else
   localparam logic [3:0] IQ_PKT_LEN   = 4'd10;
   localparam logic [3:0] STAT_PKT_LEN = 4'd5;
`endif

   // XOR of the four 7-bit payload fields of one word.
   function automatic logic [6:0] payload_xor(input logic [31:0] w);
      return w[6:0] ^ w[14:8] ^ w[22:16] ^ w[30:24];
   endfunction

endpackage

// File: rtl/pkt_word_enc.sv
// Combinational framer: picks the header or one 7-bit payload byte of a word.
module pkt_word_enc
   import sdr_pkt_pkg::*;
(
   input  logic [31:0] word,
   input  logic [3:0]  tag,
   input  logic [2:0]  slot,
   output logic [7:0]  enc_byte
);

   // Header carries the four bit-7s that the 7-bit payload bytes cannot.
   always_comb begin
      case (slot)
         3'd0:    enc_byte = {tag, word[31], word[23], word[15], word[7]};
         3'd1:    enc_byte = {1'b0, word[6:0]};
         3'd2:    enc_byte = {1'b0, word[14:8]};
         3'd3:    enc_byte = {1'b0, word[22:16]};
         3'd4:    enc_byte = {1'b0, word[30:24]};
         default: enc_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/iq_pkt_tx_sched.sv
// Round-robin packet scheduler sharing the host serial transmitter between the
// I/Q stream and status replies. Define PKT_CHECKSUM_EN for an XOR trailer byte.
module iq_pkt_tx_sched
   import sdr_pkt_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 255,
   parameter int DROP_CNT_W   = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iq_valid,
   input  logic [31:0]           iq_i,
   input  logic [31:0]           iq_q,
   input  logic                  stat_req,
   input  logic [31:0]           stat_word,
   output logic                  stat_ack,
   output logic [7:0]            tx_byte,
   output logic                  tx_send,
   input  logic                  tx_busy,
   output logic                  pkt_active,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  timeout_err
);

   localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

   logic              iq_full, stat_full;
   logic [31:0]       iq_i_r, iq_q_r, stat_r;
   tx_state_t         state;
   logic [3:0]        byte_idx, nxt_idx, last_idx;
   logic              act_iq, last_gnt_iq, cur_iq;
   logic [31:0]       act_a, act_b, cur_a, cur_b;
   logic [TMR_W-1:0]  timer;
   logic              gnt_iq, gnt_st;
   logic [31:0]       enc_word;
   logic [3:0]        enc_tag;
   logic [2:0]        enc_slot;
   logic [7:0]        enc_byte, nxt_byte;

   always_comb begin
      gnt_iq = (state == S_IDLE) && iq_full   && (!stat_full || !last_gnt_iq);
      gnt_st = (state == S_IDLE) && stat_full && (!iq_full   ||  last_gnt_iq);
   end

   assign last_idx = act_iq ? (IQ_PKT_LEN - 4'd1) : (STAT_PKT_LEN - 4'd1);

   // In IDLE the first byte is framed straight from the granted slot.
   always_comb begin
      cur_iq  = act_iq;
      cur_a   = act_a;
      cur_b   = act_b;
      nxt_idx = byte_idx + 4'd1;
      if (state == S_IDLE) begin
         cur_iq  = gnt_iq;
         cur_a   = gnt_iq ? iq_i_r : stat_r;
         cur_b   = iq_q_r;
         nxt_idx = 4'd0;
      end
      enc_word = cur_a;
      enc_tag  = cur_iq ? TAG_I : TAG_STAT;
      enc_slot = nxt_idx[2:0];
      if (cur_iq && nxt_idx >= 4'd5) begin
         enc_word = cur_b;
         enc_tag  = TAG_Q;
         enc_slot = 3'(nxt_idx - 4'd5);
      end
   end

   pkt_word_enc u_enc (
      .word     (enc_word),
      .tag      (enc_tag),
      .slot     (enc_slot),
      .enc_byte (enc_byte)
   );

`ifdef PKT_CHECKSUM_EN
   always_comb begin
      nxt_byte = enc_byte;
      if (state != S_IDLE && nxt_idx == last_idx)
         nxt_byte = {1'b0, payload_xor(cur_a) ^ (cur_iq ? payload_xor(cur_b) : 7'd0)};
   end
`else
   assign nxt_byte = enc_byte;
`endif

   // Pending slots: a strobe on the grant cycle simply refills the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iq_full   <= 1'b0;
         iq_i_r    <= '0;
         iq_q_r    <= '0;
         drop_cnt  <= '0;
         stat_full <= 1'b0;
         stat_r    <= '0;
      end else begin
         if (iq_valid) begin
            iq_i_r  <= iq_i;
            iq_q_r  <= iq_q;
            iq_full <= 1'b1;
            if (iq_full && !gnt_iq && drop_cnt != '1)
               drop_cnt <= drop_cnt + 1'b1;
         end else if (gnt_iq) begin
            iq_full <= 1'b0;
         end
         if (stat_req) begin
            stat_r    <= stat_word;
            stat_full <= 1'b1;
         end else if (gnt_st) begin
            stat_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         byte_idx    <= '0;
         act_iq      <= 1'b0;
         act_a       <= '0;
         act_b       <= '0;
         last_gnt_iq <= 1'b0;
         timer       <= '0;
         tx_byte     <= 8'h00;
         tx_send     <= 1'b0;
         stat_ack    <= 1'b0;
         pkt_active  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         tx_send  <= 1'b0;
         stat_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt_iq || gnt_st) begin
                  act_iq      <= gnt_iq;
                  act_a       <= cur_a;
                  act_b       <= iq_q_r;
                  last_gnt_iq <= gnt_iq;
                  byte_idx    <= '0;
                  tx_byte     <= nxt_byte;
                  tx_send     <= 1'b1;
                  pkt_active  <= 1'b1;
                  state       <= S_SEND;
               end
            end
            S_SEND: begin
               timer <= '0;
               state <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (tx_busy) begin
                  state <= S_WAIT_LO;
               end else if (timer == TMR_W'(BUSY_TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  state       <= S_NEXT;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_WAIT_LO: begin
               if (!tx_busy) state <= S_NEXT;
            end
            S_NEXT: begin
               if (byte_idx == last_idx) begin
                  pkt_active <= 1'b0;
                  stat_ack   <= !act_iq;
                  state      <= S_IDLE;
               end else begin
                  byte_idx <= nxt_idx;
                  tx_byte  <= nxt_byte;
                  tx_send  <= 1'b1;
                  state    <= S_SEND;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iq_pkt_tx_sched.sv
// Scoreboard bench: stimulus pushes hand-framed bytes, a monitor pops them on tx_send.
module tb_iq_pkt_tx_sched;

   localparam int BUSY_TIMEOUT = 255;
   localparam int DROP_CNT_W   = 8;
`ifdef PKT_CHECKSUM_EN
   localparam int STAT_LEN = 6;
`else
   localparam int STAT_LEN = 5;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iq_valid = 1'b0, stat_req = 1'b0, tx_busy = 1'b0;
   logic [31:0] iq_i = '0, iq_q = '0, stat_word = '0;
   logic        stat_ack, tx_send, pkt_active, timeout_err;
   logic [7:0]  tx_byte;
   logic [DROP_CNT_W-1:0] drop_cnt;

   int        checks = 0, errors = 0, cyc = 0, acks = 0, t_strobe = 0;
   logic [7:0] exp_q[$];
   int        sc_q[$];
   bit        model_en = 1'b1;

   iq_pkt_tx_sched #(.BUSY_TIMEOUT(BUSY_TIMEOUT), .DROP_CNT_W(DROP_CNT_W)) dut (
      .clk(clk), .rst(rst), .iq_valid(iq_valid), .iq_i(iq_i), .iq_q(iq_q),
      .stat_req(stat_req), .stat_word(stat_word), .stat_ack(stat_ack),
      .tx_byte(tx_byte), .tx_send(tx_send), .tx_busy(tx_busy),
      .pkt_active(pkt_active), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic pushv(input logic [79:0] v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v[8*(n-k)-1 -: 8]);
   endtask

   task automatic send_iq(input logic [31:0] i, input logic [31:0] q);
      @(posedge clk); #1;
      iq_i = i; iq_q = q; iq_valid = 1'b1; t_strobe = cyc;
      @(posedge clk); #1;
      iq_valid = 1'b0;
   endtask

   task automatic send_stat(input logic [31:0] w);
      @(posedge clk); #1;
      stat_word = w; stat_req = 1'b1;
      @(posedge clk); #1;
      stat_req = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((pkt_active === 1'b1 || exp_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_done_in_budget"}, n < budget, 1);
      exp_q.delete();
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_reset_vals(input string name);
      @(negedge clk);
      chk({name, "_tx_byte"}, tx_byte, 8'h00);
      chk({name, "_tx_send"}, tx_send, 0);
      chk({name, "_stat_ack"}, stat_ack, 0);
      chk({name, "_pkt_active"}, pkt_active, 0);
      chk({name, "_timeout_err"}, timeout_err, 0);
      chk({name, "_drop_cnt"}, drop_cnt, 0);
   endtask

   // Serial transmitter model: busy for 20 cycles after each send.
   initial forever begin
      @(negedge clk);
      if (tx_send && model_en && !rst) begin
         @(posedge clk); #1 tx_busy = 1'b1;
         repeat (20) @(posedge clk);
         #1 tx_busy = 1'b0;
      end
   end

   // Monitor
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (tx_send) begin
            sc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_send: got %0h, want no byte", tx_byte);
            end else begin
               chk($sformatf("byte%0d", sc_q.size() - 1), tx_byte, exp_q.pop_front());
            end
         end
         if (stat_ack) acks++;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int n0, a0, n;
      repeat (3) @(posedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1 rst = 1'b0;

      // basic framing and first-byte latency
      n0 = sc_q.size();
      pushv(80'h8C_01_7F_7F_00_40_00_00_00_00, 10);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h01);
`endif
      send_iq(32'h80FF7F01, 32'h0000_0000);
      n = 0;
      while (sc_q.size() == n0 && n < 10) begin @(posedge clk); n++; end
      chk("first_send_latency", (sc_q.size() > n0) ? (sc_q[n0] - t_strobe) : -1, 2);
      wait_done("basic", 600);

      // overflow: A sent, B overwritten by C, C sent next
      pushv(80'h80_01_00_00_00_40_02_00_00_00, 10);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h03);
`endif
      pushv(80'h80_03_00_00_00_40_04_00_00_00, 10);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h07);
`endif
      send_iq(32'h1, 32'h2);
      repeat (10) @(posedge clk);
      send_iq(32'hB, 32'hB);
      repeat (5) @(posedge clk);
      send_iq(32'h3, 32'h4);
      @(negedge clk);
      chk("drop_cnt_after_overwrite", drop_cnt, 1);
      wait_done("overflow", 1200);
      chk("drop_cnt_final", drop_cnt, 1);

      // round-robin tie from reset: I/Q first, then status
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      a0 = acks;
      pushv(80'h80_05_00_00_00_40_06_00_00_00, 10);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h03);
`endif
      pushv(80'hC0_78_56_34_12, 5);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h08);
`endif
      @(posedge clk); #1;
      iq_i = 32'h5; iq_q = 32'h6; iq_valid = 1'b1;
      stat_word = 32'h12345678; stat_req = 1'b1;
      @(posedge clk); #1;
      iq_valid = 1'b0; stat_req = 1'b0;
      wait_done("round_robin", 1200);
      chk("stat_ack_count_rr", acks - a0, 1);

      a0 = acks;
      pushv(80'hC0_01_01_00_00, 5);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h00);
`endif
      send_stat(32'h00000101);
      wait_done("stat_0101", 600);
      chk("stat_ack_count_0101", acks - a0, 1);
      chk("timeout_err_clear", timeout_err, 0);

      // timeout: transmitter never raises busy
      model_en = 1'b0;
      n0 = sc_q.size();
      pushv(80'hC0_7F_00_00_7F, 5);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h00);
`endif
      send_stat(32'h7F00007F);
      wait_done("timeout", 3000);
      chk("timeout_byte_count", sc_q.size() - n0, STAT_LEN);
      for (int k = n0 + 1; k < sc_q.size(); k++)
         chk($sformatf("timeout_gap%0d", k - n0),
             ((sc_q[k] - sc_q[k-1]) >= BUSY_TIMEOUT + 1) && ((sc_q[k] - sc_q[k-1]) <= BUSY_TIMEOUT + 3), 1);
      chk("timeout_err_set", timeout_err, 1);
      model_en = 1'b1;
      pushv(80'h80_00_00_00_00_40_00_00_00_00, 10);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h00);
`endif
      send_iq(32'h0, 32'h0);
      wait_done("after_timeout", 600);
      chk("timeout_err_sticky", timeout_err, 1);

      // reset mid-packet after the third byte
      n0 = sc_q.size();
      pushv(80'h80_11_00_00_00_40_22_00_00_00, 10);
      send_iq(32'h11, 32'h22);
      n = 0;
      while (sc_q.size() < n0 + 3 && n < 300) begin @(posedge clk); n++; end
      chk("mid_reset_reached_byte3", sc_q.size() - n0, 3);
      @(posedge clk); #1 rst = 1'b1;
      exp_q.delete();
      chk_reset_vals("mid_reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (30) @(posedge clk);
      chk("no_resume_after_reset", sc_q.size() - n0, 3);
      pushv(80'h80_33_00_00_00_40_00_00_00_00, 10);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h33);
`endif
      send_iq(32'h33, 32'h0);
      wait_done("restart", 600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
